// File: rtl/ahb_lite_mem_slave.sv
// rtl/ahb_lite_mem_slave.sv - AHB-Lite word-addressed RAM slave with fixed wait states and two-cycle ERROR
// Define AHB_SLV_SEQ_CHECK_EN to enable burst address/attribute checking of SEQ transfers.
module ahb_lite_mem_slave #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       MEM_DEPTH     = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_STATES   = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [DATA_WIDTH-1:0]    HRDATA
);

  localparam int     BYTES      = DATA_WIDTH / 8;
  localparam int     LOG2_BYTES = $clog2(BYTES);
  localparam int     OFF_W      = (BYTES > 1) ? LOG2_BYTES : 1;
  localparam int     IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint MEM_BYTES  = longint'(MEM_DEPTH) * longint'(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDRESS_WIDTH:0] rel_addr;
  logic [7:0]             size_mask;
  logic                   range_err, size_err, align_err, base_err, seq_err, xfer_err;
  logic                   accept;
  logic [BYTES-1:0]       lane_en;

  // The borrow bit of the subtraction flags addresses below the base.
  assign rel_addr  = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign range_err = rel_addr[ADDRESS_WIDTH] |
                     (64'(rel_addr[ADDRESS_WIDTH-1:0]) >= 64'(MEM_BYTES));
  assign size_err  = 32'(HSIZE) > 32'(LOG2_BYTES);
  assign size_mask = (8'd1 << HSIZE) - 8'd1;
  assign align_err = |(8'(HADDR) & size_mask);
  assign base_err  = range_err | size_err | align_err;
  assign xfer_err  = base_err | seq_err;

  // New address phases are only taken while this slave drives HREADYOUT high.
  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (state_q == S_DATA) ? mem[idx_q] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: state_d = S_IDLE;
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DATA;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d   = IDX_W'(rel_addr[ADDRESS_WIDTH-1:0] >> LOG2_BYTES);
      off_d   = OFF_W'(HADDR) & OFF_W'(BYTES - 1);
      size_d  = HSIZE;
      write_d = HWRITE;
      if (xfer_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Little-endian lanes covered by the latched offset and size.
  always_comb begin
    lane_en = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_en[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_en[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

`ifdef AHB_SLV_SEQ_CHECK_EN
  logic                     burst_q, burst_d;
  logic [ADDRESS_WIDTH-1:0] exp_q, exp_d;
  logic [2:0]               bsize_q, bsize_d;
  logic [2:0]               bburst_q, bburst_d;
  logic                     bwrite_q, bwrite_d;

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(
    input logic [ADDRESS_WIDTH-1:0] a,
    input logic [2:0]               sz,
    input logic [2:0]               bu
  );
    logic [ADDRESS_WIDTH-1:0] step, wrap_mask;
    step = ADDRESS_WIDTH'(1) << sz;
    case (bu)
      3'd2:    wrap_mask = (step << 2) - ADDRESS_WIDTH'(1);
      3'd4:    wrap_mask = (step << 3) - ADDRESS_WIDTH'(1);
      3'd6:    wrap_mask = (step << 4) - ADDRESS_WIDTH'(1);
      default: wrap_mask = '0;
    endcase
    if (wrap_mask == '0) next_addr = a + step;
    else                 next_addr = (a & ~wrap_mask) | ((a + step) & wrap_mask);
  endfunction

  always_comb begin
    seq_err  = 1'b0;
    burst_d  = burst_q;
    exp_d    = exp_q;
    bsize_d  = bsize_q;
    bburst_d = bburst_q;
    bwrite_d = bwrite_q;
    if (HTRANS == 2'b11) begin
      seq_err = !burst_q || (HSIZE != bsize_q) || (HWRITE != bwrite_q) ||
                (HBURST != bburst_q) || (HADDR != exp_q);
    end
    if (accept) begin
      if (base_err || seq_err) begin
        burst_d = 1'b0;
      end else begin
        burst_d  = 1'b1;
        exp_d    = next_addr(HADDR, HSIZE, HBURST);
        bsize_d  = HSIZE;
        bburst_d = HBURST;
        bwrite_d = HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      burst_q  <= 1'b0;
      exp_q    <= '0;
      bsize_q  <= '0;
      bburst_q <= '0;
      bwrite_q <= 1'b0;
    end else begin
      burst_q  <= burst_d;
      exp_q    <= exp_d;
      bsize_q  <= bsize_d;
      bburst_q <= bburst_d;
      bwrite_q <= bwrite_d;
    end
  end
`else
  logic unused_sig;
  assign seq_err    = 1'b0;
  assign unused_sig = ^{HBURST, HTRANS[0]};
`endif

endmodule
